sc_fir_engine: RTL
==================

Name: sc_fir_engine

Overview:
- Parametrised stochastic-computing FIR engine: one output sample per 2^N-cycle bitstream window, TAPS taps.
- Each tap input (binary) becomes a bitstream via comparison with external random R_y, then a per-tap sign inversion is applied.
- One tap per cycle is selected by comparing external random R_s against a runtime-programmable cumulative-weight table (CDF). A ones-counter accumulates the selected bit.
- Replaces fixed-coefficient hard-wired mux trees. Sits between the sample-window buffer and the output decimation stage.

Parameters:
- N, 12, stream precision; window length 2^N cycles; RNG width N.
- TAPS, 39, number of filter taps.
- AW, $clog2(TAPS), CDF table address width.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cfg_we  in  1  CDF/sign table write enable.
- cfg_addr  in  AW  table entry index; writes with cfg_addr >= TAPS are ignored.
- cfg_cdf  in  N+1  cumulative weight bound for entry.
- cfg_sign  in  1  tap sign, 1 = negative coefficient.
- in  in  TAPS x (N+1)  tap sample vector, unsigned binary 0..2^N.
- start  in  1  request new window; accepted only when ready=1.
- ready  out  1  engine idle, can accept start.
- R_y  in  N  comparator random number from RNG.
- R_s  in  N  tap-select random number from RNG.
- out  out  N+1 (N+2 signed with option)  window result.
- out_valid  out  1  one-cycle pulse; out is valid in that cycle.
- busy  out  1  window in progress.

Behaviour:
- Reset (reset_n=0 at clock edge):
  - state=IDLE; acc=0, cnt=0, out=0, out_valid=0, busy=0, ready=1.
  - All cdf entries = 2^N; all signs = 0.
  - Reset wins over every other input, including mid-window: the window is aborted and no out_valid is produced.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - cfg_we writes table entry[cfg_addr] in the same edge.
  - On start=1: latch in[] into the sample register, acc=0, cnt=0, go to RUN.
  - If start and cfg_we are high together, the write completes and the window uses the new table.
- RUN:
  - busy=1, ready=0; start and cfg_we are ignored, so the table is frozen.
  - Each cycle: sn[i] = (x[i] > R_y); b[i] = sn[i] ^ sign[i].
  - sel = lowest i with R_s < cdf[i]. If no entry matches, sel = TAPS-1.
  - acc <= acc + b[sel]; cnt <= cnt + 1.
  - When cnt == 2^N-1, the bit is still accumulated and the next state is DONE.
- DONE (one cycle):
  - out <= final acc; out_valid=1; go to IDLE.
  - out holds its value until the next DONE.
- Latency: start edge to out_valid = 2^N + 1 cycles.
- Width rules:
  - acc is N+1 bits, range 0..2^N inclusive; it cannot overflow.
  - x = 2^N always yields sn=1.
  - The cdf table must be monotonic non-decreasing. A non-monotonic table is undefined but must not hang the FSM.

Optional Feature:
- Macro SC_FIR_BIPOLAR_OUT_EN.
- Defined: out is N+2-bit two's complement, out = 2*acc - 2^N (bipolar decode), range -2^N..+2^N.
- Undefined: out is an N+1-bit unsigned ones count. There is no extra logic or latency in either case.

Decomposition:
- Package sc_fir_pkg:
  - default N and TAPS;
  - state enum (IDLE, RUN, DONE);
  - typedef sample_t [N:0] and cdf_t [N:0];
  - constant WINDOW = 2^N.
- Sub-module sc_cdf_select: combinational priority comparator, R_s and cdf table in, sel index out. It is reused by the planned IIR variant.

Test Plan:
- Reset: reset_n=0 for 2 cycles -> out=0, out_valid=0, busy=0, ready=1; fresh table selects tap 0.
- Single tap: default table, sign0=0, x[0]=2048, R_y = counter 0..4095 -> out_valid at cycle 4097, out=2048 (bipolar: 0).
- Negative tap: sign0=1, x[0]=4096 -> out=0 (bipolar: -4096). With sign0=0 -> out=4096 (bipolar: +4096).
- Two-tap weighting:
  - Table: cdf[0]=2048, all other entries 4096.
  - Inputs: x[0]=4096, x[1]=0, signs 0.
  - Stimulus: R_s = bit-reversed counter, R_y = counter.
  - Required: out=2048.
- Ignored inputs in RUN: start pulses and cfg_we writes of cdf[0]=0 at cnt=100 -> result identical to a clean run; the table is unchanged afterwards.
- Mid-window reset: reset_n=0 at cnt=1000 -> busy=0 and ready=1 next cycle, no out_valid. A following start runs a full 4096 cycles with the default table.

Source files
------------

// File: rtl/sc_fir_pkg.sv
// Shared constants, types and FSM encoding for the stochastic-computing FIR engine.
// Build option SC_FIR_BIPOLAR_OUT_EN widens the window result to a signed bipolar value.
package sc_fir_pkg;

    localparam int N_DEF    = 12;
    localparam int TAPS_DEF = 39;
    localparam int WINDOW   = 2 ** N_DEF;

`ifdef SC_FIR_BIPOLAR_OUT_EN
    localparam int OUT_EXTRA = 1;
`else
    localparam int OUT_EXTRA = 0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [N_DEF:0] sample_t;
    typedef logic [N_DEF:0] cdf_t;

endpackage

// File: rtl/sc_fir_engine_if.sv
// Configuration, sample and result bundle of the SC FIR engine.
// The result width grows by one bit when SC_FIR_BIPOLAR_OUT_EN is defined.
interface sc_fir_engine_if #(
    parameter int N    = sc_fir_pkg::N_DEF,
    parameter int TAPS = sc_fir_pkg::TAPS_DEF,
    parameter int AW   = $clog2(TAPS)
);

    logic                               cfg_we;
    logic [AW-1:0]                      cfg_addr;
    logic [N:0]                         cfg_cdf;
    logic                               cfg_sign;
    logic [TAPS-1:0][N:0]               in;
    logic                               start;
    logic                               ready;
    logic [N-1:0]                       R_y;
    logic [N-1:0]                       R_s;
    logic [N+sc_fir_pkg::OUT_EXTRA:0]   out;
    logic                               out_valid;
    logic                               busy;

    modport master (
        output cfg_we, cfg_addr, cfg_cdf, cfg_sign, in, start, R_y, R_s,
        input  ready, out, out_valid, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_cdf, cfg_sign, in, start, R_y, R_s,
        output ready, out, out_valid, busy
    );

endinterface

// File: rtl/sc_cdf_select.sv
// Priority comparator: picks the lowest table entry whose cumulative bound exceeds R_s.
// Falls back to the last tap when nothing matches, so a malformed table still yields a valid index.
module sc_cdf_select #(
    parameter int N    = 12,
    parameter int TAPS = 39,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic [N-1:0]          rs,
    input  logic [TAPS-1:0][N:0]  cdf,
    output logic [AW-1:0]         sel
);

    // Scanning from the top down lets the lowest matching index win.
    always_comb begin
        sel = AW'(TAPS - 1);
        for (int i = TAPS - 1; i >= 0; i--) begin
            if ({1'b0, rs} < cdf[i]) begin
                sel = AW'(i);
            end
        end
    end

endmodule

// File: rtl/sc_fir_engine.sv
// Stochastic-computing FIR engine: one ones-count per 2^N-cycle window over TAPS signed taps.
// SC_FIR_BIPOLAR_OUT_EN selects the bipolar decode 2*acc - 2^N for the result.
module sc_fir_engine
    import sc_fir_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int TAPS = TAPS_DEF,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic           clock,
    input  logic           reset_n,
    sc_fir_engine_if.slave bus
);

    localparam logic [N:0] FULL = {1'b1, {N{1'b0}}};

    state_t               state;
    logic [N:0]           acc;
    logic [N-1:0]         cnt;
    logic [TAPS-1:0][N:0] x;
    logic [TAPS-1:0][N:0] cdf;
    logic [TAPS-1:0]      sign;
    logic [TAPS-1:0]      bits;
    logic [AW-1:0]        sel;
    logic [N+OUT_EXTRA:0] result;

    always_comb begin
        bits = '0;
        for (int i = 0; i < TAPS; i++) begin
            bits[i] = (x[i] > {1'b0, bus.R_y}) ^ sign[i];
        end
    end

    sc_cdf_select #(
        .N    (N),
        .TAPS (TAPS),
        .AW   (AW)
    ) u_select (
        .rs  (bus.R_s),
        .cdf (cdf),
        .sel (sel)
    );

`ifdef SC_FIR_BIPOLAR_OUT_EN
    assign result = {acc, 1'b0} - {2'b01, {N{1'b0}}};
`else
    assign result = acc;
`endif

    // The table is only writable while idle, so it stays frozen for the whole window.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            x             <= '0;
            cdf           <= {TAPS{FULL}};
            sign          <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.ready     <= 1'b1;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cfg_we && (int'(bus.cfg_addr) < TAPS)) begin
                        cdf[bus.cfg_addr]  <= bus.cfg_cdf;
                        sign[bus.cfg_addr] <= bus.cfg_sign;
                    end
                    if (bus.start) begin
                        x         <= bus.in;
                        acc       <= '0;
                        cnt       <= '0;
                        bus.busy  <= 1'b1;
                        bus.ready <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc + {{N{1'b0}}, bits[sel]};
                    cnt <= cnt + N'(1);
                    if (cnt == {N{1'b1}}) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.out       <= result;
                    bus.out_valid <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.ready     <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
